// File: rtl/fp_sp_pkg.sv
// Shared single-precision constants and pipeline types for the FP multiply
// normalize/round back end.
//   BIAS/EXP_MAX/FRAC_W/EXP_W : IEEE-754 single-precision field geometry
//   FLAG_*                    : bit positions inside the 3-bit flag vector
//   s1_t                      : contents of the normalize stage register
package fp_sp_pkg;

  localparam int BIAS     = 127;
  localparam int EXP_MAX  = 255;
  localparam int FRAC_W   = 23;
  localparam int EXP_W    = 8;

  // Flag vector is {overflow, underflow, inexact}.
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UDF = 1;
  localparam int FLAG_INX = 0;

  // Intermediate exponent width: exp_sum - BIAS + 1 spans -127..384.
  localparam int EXP_I_W  = 10;

  typedef struct packed {
    logic               sign;
    logic [EXP_I_W-1:0] exp;     // two's complement biased exponent
    logic [FRAC_W-1:0]  frac;    // kept fraction, hidden bit removed
    logic               guard;
    logic               sticky;
    logic               zero;    // product was exactly zero
  } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even incrementer for a 23-bit fraction.
//   frac     : truncated fraction
//   g        : guard bit (first discarded bit)
//   s        : sticky bit (OR of all bits below guard)
//   frac_out : rounded fraction (wraps to zero on carry)
//   carry    : rounding carried out of the fraction field
module fp_round_rne
  import fp_sp_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              g,
  input  logic              s,
  output logic [FRAC_W-1:0] frac_out,
  output logic              carry
);

  logic inc;

  // Round up above the halfway point, or exactly at it when the LSB is odd.
  assign inc = g & (s | frac[0]);
  assign {carry, frac_out} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};

endmodule

// File: rtl/fp_mult_norm.sv
// Normalize, round and pack stage of a single-precision multiplier.
// Two-stage valid/ready pipeline: S1 normalizes the 48-bit significand
// product and forms the biased exponent, S2 rounds (RNE), detects
// overflow/underflow and packs the IEEE-754 result.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake
//   in_sign           : product sign
//   in_exp_sum        : a_exp + b_exp (both still biased)
//   in_mant_prod      : 24x24-bit significand product
//   out_valid/out_ready : output handshake
//   out_result        : packed single-precision product
//   out_flags         : {overflow, underflow, inexact}
module fp_mult_norm #(
  parameter int BIAS = fp_sp_pkg::BIAS,
  parameter int FTZ  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp_sum,
  input  logic [47:0] in_mant_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags
);

  import fp_sp_pkg::*;

  // Only flush-to-zero is implemented: results below the normal range
  // always become signed zero, so FTZ does not change the datapath.
  logic unused_ftz;
  assign unused_ftz = (FTZ != 0);

  logic        s1_valid_q, s1_valid_d;
  s1_t         s1_q, s1_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  logic        s2_advance;
  logic        norm;

  // ---------------------------------------------------------------- handshake
  assign s2_advance = !s2_valid_q | out_ready;
  // S1 can take a new tuple when empty or when its contents move to S2.
  assign in_ready   = !rst & (!s1_valid_q | s2_advance);

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

  // ---------------------------------------------------------------- S1
  // Product of two [1,2) significands lies in [1,4): bit 47 set means the
  // value is >= 2 and the binary point moves one place left.
  assign norm = in_mant_prod[47];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_d.sign   = in_sign;
        s1_d.exp    = 10'({1'b0, in_exp_sum}) - 10'(BIAS) + 10'(norm);
        s1_d.frac   = norm ? in_mant_prod[46:24] : in_mant_prod[45:23];
        s1_d.guard  = norm ? in_mant_prod[23]    : in_mant_prod[22];
        s1_d.sticky = norm ? |in_mant_prod[22:0] : |in_mant_prod[21:0];
        s1_d.zero   = (in_mant_prod == '0);
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic [FRAC_W-1:0]  frac_rnd;
  logic               rnd_carry;
  logic signed [10:0] exp_fin;
  logic [31:0]        res;
  logic [2:0]         flg;

  fp_round_rne u_round (
    .frac     (s1_q.frac),
    .g        (s1_q.guard),
    .s        (s1_q.sticky),
    .frac_out (frac_rnd),
    .carry    (rnd_carry)
  );

  // One extra bit so e+1 cannot wrap before the range checks.
  assign exp_fin = $signed({s1_q.exp[EXP_I_W-1], s1_q.exp}) + $signed({10'd0, rnd_carry});

  always_comb begin
    res = {s1_q.sign, 31'h0};
    flg = '0;
    if (s1_q.zero) begin
      // Exact zero: signed zero, no flags, exponent irrelevant.
      res = {s1_q.sign, 31'h0};
    end else if (exp_fin >= $signed(11'(EXP_MAX))) begin
      res = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flg[FLAG_OVF] = 1'b1;
      flg[FLAG_INX] = 1'b1;
    end else if (exp_fin <= 11'sd0) begin
      flg[FLAG_UDF] = 1'b1;
      flg[FLAG_INX] = 1'b1;
    end else begin
      res = {s1_q.sign, exp_fin[EXP_W-1:0], frac_rnd};
      flg[FLAG_INX] = s1_q.guard | s1_q.sticky;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = res;
        flags_d  = flg;
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= 32'h0;
      flags_q    <= 3'b000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_norm.sv
// Self-checking bench for fp_mult_norm: arithmetic reference model,
// in-order scoreboard, directed corner vectors and randomized traffic.
module tb_fp_mult_norm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp_sum;
  logic [47:0] in_mant_prod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  fp_mult_norm #(.BIAS(127), .FTZ(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp_sum   (in_exp_sum),
    .in_mant_prod (in_mant_prod),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags)
  );

  int total = 0;
  int bad   = 0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Reference: treat the product as an integer, split it at the binary point
  // into a quotient and remainder, and round by comparing the remainder with
  // one half. Returns {result[31:0], flags[2:0]}.
  function automatic logic [34:0] model(input logic s, input logic [8:0] es, input logic [47:0] p);
    longint unsigned prod, q, rem, half, f;
    int   shift, e;
    logic up, inx;
    prod = 64'(p);
    if (prod == 0) return {s, 31'h0, 3'b000};
    shift = p[47] ? 24 : 23;
    q     = prod >> shift;
    rem   = prod & ((64'd1 << shift) - 1);
    half  = 64'd1 << (shift - 1);
    up    = (rem > half) || ((rem == half) && q[0]);
    inx   = (rem != 0);
    e     = int'(es) - 127 + (p[47] ? 1 : 0);
    f     = (q & 64'h7FFFFF) + 64'(up);
    if (f == 64'h800000) begin
      f = 0;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
    if (e <= 0)   return {s, 31'h0, 3'b011};
    return {s, e[7:0], f[22:0], 2'b00, inx};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [34:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [34:0] held;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", 64'({out_valid, out_result, out_flags}), 64'({1'b1, held}));
      if (in_valid && in_ready)
        exp_q.push_back(model(in_sign, in_exp_sum, in_mant_prod));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out actual=%h_%b required=no_output", out_result, out_flags);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("result", 64'({out_result, out_flags}), 64'(e));
        end
      end
      hold_prev = out_valid && !out_ready;
      held      = {out_result, out_flags};
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------- stimulus helpers
  task automatic send(input logic s, input logic [8:0] e, input logic [47:0] p);
    int n = 0;
    in_valid     = 1'b1;
    in_sign      = s;
    in_exp_sum   = e;
    in_mant_prod = p;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=in_ready_low required=accept_within_200");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic        vs[7];
  logic [8:0]  ve[7];
  logic [47:0] vp[7];
  logic [34:0] vx[7];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vs[0] = 0; ve[0] = 9'd254; vp[0] = 48'h4000_0000_0000; vx[0] = {32'h3F800000, 3'b000};
    vs[1] = 1; ve[1] = 9'd254; vp[1] = 48'h9000_0000_0000; vx[1] = {32'hC0100000, 3'b000};
    vs[2] = 0; ve[2] = 9'd400; vp[2] = 48'h4000_0000_0000; vx[2] = {32'h7F800000, 3'b101};
    vs[3] = 0; ve[3] = 9'd100; vp[3] = 48'h4000_0000_0000; vx[3] = {32'h00000000, 3'b011};
    vs[4] = 0; ve[4] = 9'd254; vp[4] = 48'h4000_0040_0000; vx[4] = {32'h3F800000, 3'b001};
    vs[5] = 0; ve[5] = 9'd254; vp[5] = 48'h4000_00C0_0000; vx[5] = {32'h3F800002, 3'b001};
    vs[6] = 0; ve[6] = 9'd254; vp[6] = 48'h7FFF_FFC0_0000; vx[6] = {32'h40000000, 3'b001};

    // Reset with junk on the input that must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_exp_sum = 9'd300;
    in_mant_prod = 48'hFFFF_FFFF_FFFF; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_flags",  64'(out_flags),  64'd0);

    // Pin the model itself against hand-computed results.
    for (int i = 0; i < 7; i++)
      check($sformatf("model_pin%0d", i), 64'(model(vs[i], ve[i], vp[i])), 64'(vx[i]));
    check("model_neg_zero", 64'(model(1'b1, 9'd300, 48'h0)), 64'({32'h80000000, 3'b000}));

    // Release reset and issue the first vector immediately: latency check.
    @(posedge clk);
    #1;
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_sign = vs[0]; in_exp_sum = ve[0]; in_mant_prod = vp[0];
    @(negedge clk);
    check("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_cycle1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency_cycle2_out_valid", 64'(out_valid), 64'd1);
    check("latency_cycle2_result", 64'({out_result, out_flags}), 64'(vx[0]));
    @(posedge clk);
    #1;

    for (int i = 1; i < 7; i++) send(vs[i], ve[i], vp[i]);
    drain();

    // Back-pressure: four tuples back to back, out_ready low for five cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vs[i + 1], ve[i + 1], vp[i + 1]);
      end
      begin
        repeat (3) @(negedge clk);
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Mid-operation reset discards in-flight tuples.
    out_ready = 1'b0;
    send(1'b0, 9'd200, 48'h5555_5555_5555);
    send(1'b1, 9'd210, 48'hAAAA_AAAA_AAAA);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid",  64'(out_valid),  64'd0);
    check("midrst_out_result", 64'(out_result), 64'd0);
    check("midrst_out_flags",  64'(out_flags),  64'd0);
    check("midrst_in_ready",   64'(in_ready),   64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Randomized traffic with random downstream stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [23:0] a, b;
      logic [47:0] p;
      logic [8:0]  e;
      int r;
      r = int'($urandom_range(0, 9));
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      p = 48'(a) * 48'(b);
      if (r == 0) p = 48'h0;
      if (r == 1) p = 48'({$urandom, $urandom});
      if (r == 2) p = (p & ~48'h7F_FFFF) | 48'h40_0000;
      if (r == 3) p = (p & ~48'hFF_FFFF) | 48'h80_0000;
      case ($urandom_range(0, 3))
        0:       e = 9'($urandom_range(0, 510));
        1:       e = 9'($urandom_range(115, 140));
        2:       e = 9'($urandom_range(370, 390));
        default: e = 9'($urandom_range(140, 370));
      endcase
      send(1'($urandom), e, p);
    end
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_norm.md
FP_MULT_NORM -- requirements
Module: fp_mult_norm

Interface
REQ-001 SHALL have parameter BIAS, default 127, meaning the single-precision exponent bias.
REQ-002 SHALL have parameter FTZ, default 1, meaning results below the normal range are flushed to signed zero; no subnormals are produced.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream operand tuple is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the tuple this cycle.
REQ-007 SHALL have port in_sign, input, 1 bit: product sign, equal to a_sign XOR b_sign.
REQ-008 SHALL have port in_exp_sum, input, 9 bits: unbiased-adder sum a_exp + b_exp, range 0..510.
REQ-009 SHALL have port in_mant_prod, input, 48 bits: product of the two 24-bit significands with hidden bits.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port out_result, output, 32 bits: IEEE-754 single-precision product.
REQ-013 SHALL have port out_flags, output, 3 bits: {overflow, underflow, inexact}.

Function
REQ-014 SHALL transfer a tuple on the input side only when in_valid and in_ready are both high in the same cycle, and on the output side only when out_valid and out_ready are both high in the same cycle.
REQ-015 SHALL implement a 2-stage pipeline, S1 normalize then S2 round/pack, each stage with its own valid bit; latency from accept to out_valid is 2 cycles, throughput is 1 per cycle.
REQ-016 SHALL advance a stage when it is empty or its successor advances; in_ready = !s1_valid | s1_advance; S2 advances when !s2_valid | out_ready.
REQ-017 SHALL hold out_result and out_flags stable while out_valid is high and out_ready is low.
REQ-018 S1 SHALL set n = in_mant_prod[47]. The kept 23-bit fraction is prod[46:24] if n=1, else prod[45:23]. Guard G is the next bit down. Sticky S is the OR of all lower bits.
REQ-019 S1 SHALL compute the biased exponent e = in_exp_sum - BIAS + n as a 10-bit signed value, range -127..384.
REQ-020 S2 SHALL round to nearest, ties to even: increment the fraction iff G & (S | frac[0]).
REQ-021 SHALL, when rounding carries out of the 23-bit fraction, set the fraction to 0 and use e+1.
REQ-022 SHALL, if the final e >= 255, output {sign, 8'hFF, 23'h0} with overflow=1 and inexact=1.
REQ-023 SHALL, if the final e <= 0, output {sign, 31'h0} with underflow=1, and inexact=1 unless in_mant_prod==0.
REQ-024 SHALL, if in_mant_prod==0, output signed zero with all flags 0, regardless of in_exp_sum.
REQ-025 SHALL otherwise output {sign, e[7:0], frac} with inexact = G|S.
REQ-026 SHALL NOT handle Inf or NaN operands; upstream handles those and bypasses this block.

Reset
REQ-027 SHALL, on rst high at a clock edge, clear s1_valid and s2_valid, and set out_valid=0, out_result=32'h0, out_flags=3'b000.
REQ-028 SHALL discard in-flight tuples when rst is asserted mid-operation; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-029 SHALL ignore in_valid while rst is high.

Structure
REQ-030 SHALL take BIAS, EXP_MAX=255, FRAC_W=23, EXP_W=8 and the flag bit indices from shared package fp_sp_pkg.
REQ-031 SHALL place the RNE increment and carry logic in combinational sub-module fp_round_rne, with inputs frac, G, S and outputs frac_out, carry.

Verification
REQ-032 SHALL verify: exp_sum=254, prod=48'h4000_0000_0000, sign=0 -> out_result=32'h3F800000, flags=000, 2 cycles after accept.
REQ-033 SHALL verify: exp_sum=254, prod=48'h9000_0000_0000, sign=1 -> out_result=32'hC0100000, flags=000.
REQ-034 SHALL verify: exp_sum=400, prod=48'h4000_0000_0000 -> 32'h7F800000, flags=101; and exp_sum=100, same prod -> 32'h00000000, flags=011.
REQ-035 SHALL verify the RNE tie: exp_sum=254, prod=48'h4000_0040_0000 (G=1, S=0, LSB=0) -> 32'h3F800000, inexact=1; and prod=48'h4000_00C0_0000 -> 32'h3F800002.
REQ-036 SHALL verify a carry-out: prod=48'h7FFF_FFC0_0000, exp_sum=254 -> 32'h40000000.
REQ-037 SHALL verify back-pressure: 4 back-to-back tuples with out_ready held low for 5 cycles -> in_ready low once both stages are full, no loss or duplication, and results emitted in order once out_ready rises.
